printer_rx: RTL and testbench

PRINTER_RX -- requirements
Module: printer_rx

---
 rtl/printer_rx_if.sv | 22 ++
 rtl/printer_rx.sv | 152 +++++++++++++++
 tb/tb_printer_rx.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/printer_rx_if.sv
// Byte handshake between the print output controller and the receiver.
//   print_data    : byte offered by the controller
//   pulse_request : controller strobe; its rising edge marks print_data valid
//   print_ready   : receiver status, 1 = a byte can be accepted
// master = controller side, slave = receiver side.
interface printer_rx_if;
  logic [7:0] print_data;
  logic       pulse_request;
  logic       print_ready;

  modport master (
    output print_data,
    output pulse_request,
    input  print_ready
  );

  modport slave (
    input  print_data,
    input  pulse_request,
    output print_ready
  );
endinterface

// File: rtl/printer_rx.sv
// Printer receiver: captures bytes on the rising edge of pulse_request,
// buffers them in a small FIFO and feeds a print engine that spends
// PRINT_CYCLES clocks per byte.
// Ports:
//   clk, rst_n     : system clock, synchronous active-low reset
//   bus (slave)    : print_data / pulse_request in, print_ready out
//   paper_out      : 1 = engine must not start a new byte
//   clear_err      : 1 = clear the sticky overflow flag
//   printed_data   : byte most recently printed
//   printed_valid  : one-cycle strobe per printed byte
//   char_count     : bytes printed since reset (wraps at 16 bits)
//   overflow_err   : sticky, a byte arrived while the FIFO was full
module printer_rx #(
  parameter int FIFO_DEPTH   = 4,
  parameter int PRINT_CYCLES = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  printer_rx_if.slave   bus,
  input  logic          paper_out,
  input  logic          clear_err,
  output logic [7:0]    printed_data,
  output logic          printed_valid,
  output logic [15:0]   char_count,
  output logic          overflow_err
);

  localparam int PW   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW   = PW + 1;
  localparam int CNTW = (PRINT_CYCLES > 1) ? $clog2(PRINT_CYCLES) : 1;

  localparam logic [1:0] S_IDLE     = 2'd0;
  localparam logic [1:0] S_LOAD     = 2'd1;
  localparam logic [1:0] S_PRINTING = 2'd2;
  localparam logic [1:0] S_DONE     = 2'd3;

  logic [7:0]      mem [FIFO_DEPTH];

  logic            pulse_q;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            print_ready_q, print_ready_d;
  logic [1:0]      state_q, state_d;
  logic [CNTW-1:0] cycle_q, cycle_d;
  logic [7:0]      work_q, work_d;
  logic [7:0]      printed_data_q, printed_data_d;
  logic            printed_valid_q, printed_valid_d;
  logic [15:0]     char_count_q, char_count_d;
  logic            overflow_q, overflow_d;

  logic capture, pop, push_ok;

  always_comb begin
    capture = bus.pulse_request & ~pulse_q;
    pop     = (state_q == S_IDLE) && (count_q != '0) && !paper_out;
    // A full FIFO can still take a byte when the engine frees a slot this cycle.
    push_ok = capture && ((count_q < CW'(FIFO_DEPTH)) || pop);

    wr_ptr_d = push_ok ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d = pop     ? rd_ptr_q + PW'(1) : rd_ptr_q;

    count_d = count_q;
    case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase

    // Ready drops while the strobe is high so one held pulse is never
    // mistaken by the controller for room for another byte.
    print_ready_d = (count_d < CW'(FIFO_DEPTH)) & ~bus.pulse_request;

    // A new overflow wins over a simultaneous clear.
    if (capture && !push_ok) overflow_d = 1'b1;
    else if (clear_err)      overflow_d = 1'b0;
    else                     overflow_d = overflow_q;

    state_d         = state_q;
    cycle_d         = cycle_q;
    work_d          = work_q;
    printed_data_d  = printed_data_q;
    printed_valid_d = 1'b0;
    char_count_d    = char_count_q;

    case (state_q)
      S_IDLE: begin
        if (pop) begin
          work_d  = mem[rd_ptr_q];
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        cycle_d = CNTW'(PRINT_CYCLES - 1);
        state_d = S_PRINTING;
      end
      S_PRINTING: begin
        // paper_out is deliberately ignored here: a started byte completes.
        if (cycle_q == '0) state_d = S_DONE;
        else               cycle_d = cycle_q - CNTW'(1);
      end
      default: begin
        printed_data_d  = work_q;
        printed_valid_d = 1'b1;
        char_count_d    = char_count_q + 16'd1;
        state_d         = S_IDLE;
      end
    endcase
  end

  // Buffer storage; stale contents are harmless because the pointers reset.
  always_ff @(posedge clk) begin
    if (rst_n && push_ok) mem[wr_ptr_q] <= bus.print_data;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pulse_q         <= 1'b0;
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      count_q         <= '0;
      print_ready_q   <= 1'b1;
      state_q         <= S_IDLE;
      cycle_q         <= '0;
      work_q          <= 8'h00;
      printed_data_q  <= 8'h00;
      printed_valid_q <= 1'b0;
      char_count_q    <= 16'h0000;
      overflow_q      <= 1'b0;
    end else begin
      pulse_q         <= bus.pulse_request;
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      count_q         <= count_d;
      print_ready_q   <= print_ready_d;
      state_q         <= state_d;
      cycle_q         <= cycle_d;
      work_q          <= work_d;
      printed_data_q  <= printed_data_d;
      printed_valid_q <= printed_valid_d;
      char_count_q    <= char_count_d;
      overflow_q      <= overflow_d;
    end
  end

  assign bus.print_ready = print_ready_q;
  assign printed_data    = printed_data_q;
  assign printed_valid   = printed_valid_q;
  assign char_count      = char_count_q;
  assign overflow_err    = overflow_q;

endmodule

// File: tb/tb_printer_rx.sv
module tb_printer_rx;
  localparam int FIFO_DEPTH   = 4;
  localparam int PRINT_CYCLES = 8;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        paper_out;
  logic        clear_err;
  logic [7:0]  printed_data;
  logic        printed_valid;
  logic [15:0] char_count;
  logic        overflow_err;

  printer_rx_if bus_if ();

  printer_rx #(
    .FIFO_DEPTH   (FIFO_DEPTH),
    .PRINT_CYCLES (PRINT_CYCLES)
  ) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .bus           (bus_if),
    .paper_out     (paper_out),
    .clear_err     (clear_err),
    .printed_data  (printed_data),
    .printed_valid (printed_valid),
    .char_count    (char_count),
    .overflow_err  (overflow_err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [7:0] data;
    int         due;   // expected cycle of printed_valid, -1 = not checked
  } exp_t;

  exp_t        exp_q[$];
  logic [15:0] exp_count = 16'h0000;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endtask

  // Monitor: every printed byte is compared with the head of the scoreboard.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (printed_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_print actual=0x%02h required=none", printed_data);
        end else begin
          e = exp_q.pop_front();
          exp_count = exp_count + 16'd1;
          check("printed_data", {24'h0, printed_data}, {24'h0, e.data});
          check("char_count", {16'h0, char_count}, {16'h0, exp_count});
          if (e.due >= 0) check("latency", cyc, e.due);
          $display("print data=0x%02h count=%0d cycle=%0d", printed_data, char_count, cyc);
        end
      end
    end
  end

  // One byte transfer: pulse held for 'hold' edges, then one low edge.
  task automatic send(input logic [7:0] d, input int hold, input bit accept,
                      input bit chk_lat, input bit with_clear);
    int t0;
    @(negedge clk);
    bus_if.print_data    = d;
    bus_if.pulse_request = 1'b1;
    clear_err            = with_clear;
    for (int i = 0; i < hold; i++) begin
      @(posedge clk);
      #1;
      if (i == 0) begin
        t0 = cyc;
        if (accept) exp_q.push_back('{d, chk_lat ? t0 + PRINT_CYCLES + 3 : -1});
      end
      @(negedge clk);
      clear_err = 1'b0;
      check("ready_low_in_pulse", {31'h0, bus_if.print_ready}, 32'h0);
    end
    bus_if.pulse_request = 1'b0;
    @(posedge clk);
    $display("send data=0x%02h hold=%0d accept=%0d", d, hold, accept);
  endtask

  task automatic wait_drain();
    int n = 0;
    while (exp_q.size() != 0 && n < 300) begin
      @(negedge clk);
      n++;
    end
    check("drain_timeout", exp_q.size(), 0);
    repeat (3) @(negedge clk);
  endtask

  initial begin
    rst_n                = 1'b0;
    paper_out            = 1'b0;
    clear_err            = 1'b0;
    bus_if.print_data    = 8'h00;
    bus_if.pulse_request = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_ready", {31'h0, bus_if.print_ready}, 32'h1);
    check("rst_valid", {31'h0, printed_valid}, 32'h0);
    check("rst_data", {24'h0, printed_data}, 32'h0);
    check("rst_count", {16'h0, char_count}, 32'h0);
    check("rst_overflow", {31'h0, overflow_err}, 32'h0);
    rst_n = 1'b1;

    // Single byte, latency PRINT_CYCLES+3 from capture.
    send(8'h41, 2, 1'b1, 1'b1, 1'b0);
    wait_drain();

    // Held pulse gives exactly one byte.
    send(8'h55, 10, 1'b1, 1'b1, 1'b0);
    @(negedge clk);
    check("ready_after_pulse", {31'h0, bus_if.print_ready}, 32'h1);
    wait_drain();

    // Fill and overflow with the engine held off.
    paper_out = 1'b1;
    for (int i = 1; i <= 3; i++) send(8'(i), 1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("ready_after_3", {31'h0, bus_if.print_ready}, 32'h1);
    send(8'h04, 1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("ready_full", {31'h0, bus_if.print_ready}, 32'h0);
    check("overflow_before", {31'h0, overflow_err}, 32'h0);
    send(8'h05, 1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("overflow_set", {31'h0, overflow_err}, 32'h1);
    paper_out = 1'b0;
    wait_drain();
    check("overflow_sticky", {31'h0, overflow_err}, 32'h1);

    // Clear alone, then clear racing a fresh overflow.
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clear_alone", {31'h0, overflow_err}, 32'h0);
    paper_out = 1'b1;
    for (int i = 1; i <= 4; i++) send(8'h10 + 8'(i), 1, 1'b1, 1'b0, 1'b0);
    send(8'h15, 1, 1'b0, 1'b0, 1'b1);
    @(negedge clk);
    check("clear_race", {31'h0, overflow_err}, 32'h1);
    clear_err = 1'b1;
    @(negedge clk);
    clear_err = 1'b0;
    check("clear_after_race", {31'h0, overflow_err}, 32'h0);
    paper_out = 1'b0;
    wait_drain();

    // Counter wrap.
    @(negedge clk);
    force dut.char_count_q = 16'hFFFF;
    @(negedge clk);
    release dut.char_count_q;
    check("count_forced", {16'h0, char_count}, 32'h0000FFFF);
    exp_count = 16'hFFFF;
    send(8'hA5, 1, 1'b1, 1'b0, 1'b0);
    wait_drain();
    check("count_wrapped", {16'h0, char_count}, 32'h0);

    // Reset while printing with two bytes queued.
    send(8'h61, 1, 1'b1, 1'b0, 1'b0);
    send(8'h62, 1, 1'b1, 1'b0, 1'b0);
    send(8'h63, 1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    exp_q.delete();
    exp_count = 16'h0000;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("midrst_ready", {31'h0, bus_if.print_ready}, 32'h1);
    check("midrst_count", {16'h0, char_count}, 32'h0);
    check("midrst_valid", {31'h0, printed_valid}, 32'h0);
    check("midrst_data", {24'h0, printed_data}, 32'h0);
    rst_n = 1'b1;
    repeat (40) @(negedge clk);
    check("post_rst_count", {16'h0, char_count}, 32'h0);
    check("post_rst_ready", {31'h0, bus_if.print_ready}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
